// File: rtl/phy_tx_stim_gen.sv
`default_nettype none
// phy_tx_stim_gen: N-lane burst traffic generator on a clk/4 tick plus a serial lane comparator.
// Rev 1.0 - initial release
module phy_tx_stim_gen #(
  parameter int LANES = 2,
  parameter int WIDTH = 8,
  parameter int CFG_W = 4,
  parameter int ERR_W = 16
) (
  input  logic                   clk_8f,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [CFG_W-1:0]       burst_len,
  input  logic [CFG_W-1:0]       gap_len,
  input  logic [CFG_W-1:0]       lane_skew,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       pattern,
  input  logic                   cmp_en,
  input  logic [LANES-1:0]       ser_a,
  input  logic [LANES-1:0]       ser_b,
  output logic                   tick_2f,
  output logic [LANES-1:0]       validout,
  output logic [LANES*WIDTH-1:0] data_out,
  output logic                   busy,
  output logic [ERR_W-1:0]       err_count,
  output logic [LANES-1:0]       err_lane
);

  localparam int DW = CFG_W + $clog2(LANES);
  localparam int PW = $clog2(LANES + 1);
  localparam int SW = ERR_W + PW;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_GAP} lane_state_e;

  logic [1:0]       div_q;
  logic [CFG_W-1:0] blen_q, gap_q, skew_q;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] pat_q;
  logic [ERR_W-1:0] err_q;
  logic [LANES-1:0] errl_q;
  logic [LANES-1:0] idle_w;
  logic             capture_w;

  assign tick_2f   = (div_q == 2'd3);
  assign busy      = ~(&idle_w);
  assign capture_w = tick_2f & enable & (&idle_w);

  // On the capture tick the lanes already act on the live inputs.
  logic [CFG_W-1:0] blen_w, gap_w, skew_w, blen_m1_w, gap_m1_w;
  logic [1:0]       mode_w;
  logic [WIDTH-1:0] pat_w;
  assign blen_w    = capture_w ? burst_len : blen_q;
  assign gap_w     = capture_w ? gap_len   : gap_q;
  assign skew_w    = capture_w ? lane_skew : skew_q;
  assign mode_w    = capture_w ? mode      : mode_q;
  assign pat_w     = capture_w ? pattern   : pat_q;
  assign blen_m1_w = (blen_w == '0) ? '0 : blen_w - 1'b1;
  assign gap_m1_w  = gap_w - 1'b1;

  function automatic logic [WIDTH-1:0] first_word(input logic [1:0] m, input logic [WIDTH-1:0] p);
    case (m)
      2'b01, 2'b11: first_word = p;
      default:      first_word = WIDTH'(1);
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] next_word(input logic [1:0] m, input logic [WIDTH-1:0] d);
    case (m)
      2'b00:   next_word = d + 1'b1;
      2'b10:   next_word = (d << 1) | (d >> (WIDTH - 1));
      2'b11:   next_word = ~d;
      default: next_word = d;
    endcase
  endfunction

  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      blen_q <= '0;
      gap_q  <= '0;
      skew_q <= '0;
      mode_q <= '0;
      pat_q  <= '0;
    end else begin
      div_q <= div_q + 1'b1;
      if (capture_w) begin
        blen_q <= burst_len;
        gap_q  <= gap_len;
        skew_q <= lane_skew;
        mode_q <= mode;
        pat_q  <= pattern;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_state_e      state_q, state_d;
    logic [DW-1:0]    cnt_q, cnt_d, delay_w;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    assign delay_w = DW'(i) * DW'(skew_w);

    always_ff @(posedge clk_8f or posedge reset) begin
      if (reset) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        data_q  <= data_d;
        valid_q <= valid_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      valid_d = valid_q;
      if (!enable) begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end else if (tick_2f) begin
        case (state_q)
          S_IDLE: begin
            if (capture_w) begin
              if (delay_w == '0) begin
                state_d = S_BURST;
                valid_d = 1'b1;
                data_d  = first_word(mode_w, pat_w);
                cnt_d   = DW'(blen_m1_w);
              end else begin
                state_d = S_WAIT;
                cnt_d   = delay_w;
              end
            end
          end
          S_WAIT: begin
            if (cnt_q == DW'(1)) begin
              state_d = S_BURST;
              valid_d = 1'b1;
              data_d  = first_word(mode_w, pat_w);
              cnt_d   = DW'(blen_m1_w);
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
          S_BURST: begin
            if (cnt_q != '0) begin
              cnt_d  = cnt_q - 1'b1;
              data_d = next_word(mode_w, data_q);
            end else if (gap_w == '0) begin
              cnt_d  = DW'(blen_m1_w);
              data_d = next_word(mode_w, data_q);
            end else begin
              state_d = S_GAP;
              valid_d = 1'b0;
              cnt_d   = DW'(gap_m1_w);
            end
          end
          S_GAP: begin
            if (cnt_q == '0) begin
              state_d = S_BURST;
              valid_d = 1'b1;
              data_d  = next_word(mode_w, data_q);
              cnt_d   = DW'(blen_m1_w);
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    assign validout[i]                  = valid_q;
    assign data_out[i*WIDTH +: WIDTH]   = data_q;
    assign idle_w[i]                    = (state_q == S_IDLE);
  end

  logic [LANES-1:0] diff_w;
  logic [PW-1:0]    mcnt_w;
  logic [SW-1:0]    sum_w;
  assign diff_w = ser_a ^ ser_b;
  assign sum_w  = SW'(err_q) + SW'(mcnt_w);

  always_comb begin
    mcnt_w = '0;
    for (int k = 0; k < LANES; k++) mcnt_w = mcnt_w + PW'(diff_w[k]);
  end

  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      err_q  <= '0;
      errl_q <= '0;
    end else if (cmp_en && enable) begin
      err_q  <= (|sum_w[SW-1:ERR_W]) ? {ERR_W{1'b1}} : sum_w[ERR_W-1:0];
      errl_q <= errl_q | diff_w;
    end
  end

  assign err_count = err_q;
  assign err_lane  = errl_q;

endmodule
`default_nettype wire

// File: tb/tb_phy_tx_stim_gen.sv
`default_nettype none
// tb_phy_tx_stim_gen: scoreboard bench for the 2-lane, 8-bit configuration.
module tb_phy_tx_stim_gen;

  logic        clk_8f = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  burst_len = '0, gap_len = '0, lane_skew = '0;
  logic [1:0]  mode = '0;
  logic [7:0]  pattern = '0;
  logic        cmp_en = 1'b0;
  logic [1:0]  ser_a = '0, ser_b = '0;
  logic        tick_2f;
  logic [1:0]  validout;
  logic [15:0] data_out;
  logic        busy;
  logic [15:0] err_count;
  logic [1:0]  err_lane;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0] v;
    logic [7:0] d0;
    logic [7:0] d1;
  } exp_t;
  exp_t sb[$];

  phy_tx_stim_gen #(.LANES(2), .WIDTH(8), .CFG_W(4), .ERR_W(16)) dut (
    .clk_8f(clk_8f), .reset(reset), .enable(enable),
    .burst_len(burst_len), .gap_len(gap_len), .lane_skew(lane_skew),
    .mode(mode), .pattern(pattern), .cmp_en(cmp_en),
    .ser_a(ser_a), .ser_b(ser_b), .tick_2f(tick_2f),
    .validout(validout), .data_out(data_out), .busy(busy),
    .err_count(err_count), .err_lane(err_lane)
  );

  always #5 clk_8f = ~clk_8f;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1);
    exp_t e;
    e.v = v; e.d0 = d0; e.d1 = d1;
    sb.push_back(e);
  endtask

  // Advance to just after the next edge on which tick_2f was high.
  task automatic next_tick();
    int n = 0;
    while (tick_2f !== 1'b1 && n < 8) begin
      @(posedge clk_8f); #1;
      n++;
    end
    if (n >= 8) check_val("tick_timeout", 64'(tick_2f), 64'd1);
    @(posedge clk_8f); #1;
  endtask

  task automatic run_stream(input string name, input int n);
    exp_t e;
    for (int t = 1; t <= n; t++) begin
      next_tick();
      if (sb.size() == 0) begin
        check_val($sformatf("%s_sb_empty", name), 64'd0, 64'd1);
      end else begin
        e = sb.pop_front();
        check_val($sformatf("%s_t%0d_valid", name, t), 64'(validout), 64'(e.v));
        if (e.v[0]) check_val($sformatf("%s_t%0d_d0", name, t), 64'(data_out[7:0]), 64'(e.d0));
        if (e.v[1]) check_val($sformatf("%s_t%0d_d1", name, t), 64'(data_out[15:8]), 64'(e.d1));
      end
    end
  endtask

  task automatic release_reset();
    @(negedge clk_8f);
    reset = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk_8f); #1;
      check_val($sformatf("tick_after_edge%0d", e), 64'(tick_2f), (e == 3) ? 64'd1 : 64'd0);
    end
  endtask

  task automatic drop_enable();
    @(negedge clk_8f);
    enable = 1'b0;
    repeat (2) @(negedge clk_8f);
  endtask

  task automatic set_cfg(input logic [3:0] bl, input logic [3:0] gl, input logic [3:0] sk,
                         input logic [1:0] md, input logic [7:0] pt);
    burst_len = bl; gap_len = gl; lane_skew = sk; mode = md; pattern = pt;
  endtask

  logic [7:0] w0, w1;

  initial begin
    repeat (3) @(posedge clk_8f);
    #1;
    check_val("rst_valid", 64'(validout), 64'd0);
    check_val("rst_data", 64'(data_out), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_tick", 64'(tick_2f), 64'd0);
    check_val("rst_err", 64'(err_count), 64'd0);

    // Increment mode with bursts, gaps and one tick of skew.
    set_cfg(4'd4, 4'd2, 4'd1, 2'b00, 8'h00);
    enable = 1'b1;
    push_exp(2'b01, 8'd1, 8'd0);
    push_exp(2'b11, 8'd2, 8'd1);
    push_exp(2'b11, 8'd3, 8'd2);
    push_exp(2'b11, 8'd4, 8'd3);
    push_exp(2'b10, 8'd4, 8'd4);
    push_exp(2'b00, 8'd4, 8'd4);
    push_exp(2'b01, 8'd5, 8'd4);
    push_exp(2'b11, 8'd6, 8'd5);
    release_reset();
    run_stream("inc", 8);
    check_val("inc_busy", 64'(busy), 64'd1);

    // Enable drop is not tick-gated and holds the data.
    enable = 1'b0;
    @(posedge clk_8f); #1;
    check_val("drop_valid", 64'(validout), 64'd0);
    check_val("drop_busy", 64'(busy), 64'd0);
    check_val("drop_data", 64'(data_out), 64'h0506);

    @(negedge clk_8f);
    enable = 1'b1;
    push_exp(2'b01, 8'd1, 8'd0);
    push_exp(2'b11, 8'd2, 8'd1);
    run_stream("reen", 2);
    drop_enable();

    // Walking one, continuous valid, burst_len 0; mid-run config change ignored.
    set_cfg(4'd0, 4'd0, 4'd1, 2'b10, 8'h00);
    for (int t = 1; t <= 10; t++) begin
      w0 = 8'd1 << ((t - 1) % 8);
      w1 = (t >= 2) ? 8'd1 << ((t - 2) % 8) : 8'd0;
      push_exp((t == 1) ? 2'b01 : 2'b11, w0, w1);
    end
    @(negedge clk_8f);
    enable = 1'b1;
    run_stream("walk_a", 3);
    set_cfg(4'd1, 4'd5, 4'd3, 2'b01, 8'h3C);
    run_stream("walk_b", 7);
    drop_enable();

    // Alternate pattern.
    set_cfg(4'd2, 4'd0, 4'd1, 2'b11, 8'hA5);
    push_exp(2'b01, 8'hA5, 8'h00);
    push_exp(2'b11, 8'h5A, 8'hA5);
    push_exp(2'b11, 8'hA5, 8'h5A);
    push_exp(2'b11, 8'h5A, 8'hA5);
    @(negedge clk_8f);
    enable = 1'b1;
    run_stream("alt", 4);
    drop_enable();

    // Constant pattern, burst 3, single-tick gap.
    set_cfg(4'd3, 4'd1, 4'd1, 2'b01, 8'hA5);
    push_exp(2'b01, 8'hA5, 8'h00);
    push_exp(2'b11, 8'hA5, 8'hA5);
    push_exp(2'b11, 8'hA5, 8'hA5);
    push_exp(2'b10, 8'hA5, 8'hA5);
    push_exp(2'b01, 8'hA5, 8'hA5);
    @(negedge clk_8f);
    enable = 1'b1;
    run_stream("const", 5);

    // Comparator.
    @(negedge clk_8f);
    cmp_en = 1'b1; ser_a = 2'b11; ser_b = 2'b01;
    repeat (3) @(negedge clk_8f);
    cmp_en = 1'b0;
    check_val("cmp_cnt3", 64'(err_count), 64'd3);
    check_val("cmp_lane10", 64'(err_lane), 64'b10);
    ser_b = 2'b00; cmp_en = 1'b1;
    @(negedge clk_8f);
    cmp_en = 1'b0;
    check_val("cmp_cnt5", 64'(err_count), 64'd5);
    check_val("cmp_lane11", 64'(err_lane), 64'b11);
    repeat (2) @(negedge clk_8f);
    check_val("cmp_off_hold", 64'(err_count), 64'd5);
    enable = 1'b0; cmp_en = 1'b1;
    repeat (2) @(negedge clk_8f);
    check_val("cmp_disabled_hold", 64'(err_count), 64'd5);
    enable = 1'b1;
    repeat (32770) @(negedge clk_8f);
    cmp_en = 1'b0;
    check_val("cmp_sat", 64'(err_count), 64'hFFFF);
    check_val("cmp_lane_sticky", 64'(err_lane), 64'b11);

    // Asynchronous reset mid-run.
    next_tick();
    next_tick();
    check_val("pre_rst_busy", 64'(busy), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check_val("arst_valid", 64'(validout), 64'd0);
    check_val("arst_data", 64'(data_out), 64'd0);
    check_val("arst_busy", 64'(busy), 64'd0);
    check_val("arst_err", 64'(err_count), 64'd0);
    check_val("arst_lane", 64'(err_lane), 64'd0);
    check_val("arst_tick", 64'(tick_2f), 64'd0);
    enable = 1'b0;
    repeat (2) @(negedge clk_8f);
    release_reset();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/phy_tx_stim_gen.md
Name: phy_tx_stim_gen

Overview:
- Synthesizable, parametrised multi-lane traffic generator and serial-lane comparator for phy_tx bring-up.
- Runs from the fast clock. Produces a 2f-rate strobe and per-lane valid/data bursts with programmable length, gap, inter-lane skew and data pattern.
- Compares two serial implementations lane by lane (e.g. conductual vs estructural) and counts mismatches.
- Generalises the fixed 2-lane, 8-bit, hand-scripted stimulus to N lanes, any width and four pattern modes.

Parameters:
- LANES, 2, number of lanes.
- WIDTH, 8, data width per lane.
- CFG_W, 4, width of burst_len, gap_len and lane_skew.
- ERR_W, 16, width of err_count.

Ports:
- clk_8f  in  1  fast clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run generator.
- burst_len  in  CFG_W  valid ticks per burst; 0 treated as 1.
- gap_len  in  CFG_W  idle ticks between bursts; 0 = continuous valid.
- lane_skew  in  CFG_W  tick delay between start of lane i and lane i+1.
- mode  in  2  00 increment, 01 constant, 10 walking-one, 11 alternate pattern/~pattern.
- pattern  in  WIDTH  constant/alternate pattern value.
- cmp_en  in  1  enable comparator.
- ser_a  in  LANES  serial lane outputs, implementation A.
- ser_b  in  LANES  serial lane outputs, implementation B.
- tick_2f  out  1  one-cycle strobe every 4th clk_8f cycle.
- validout  out  LANES  per-lane valid.
- data_out  out  LANES*WIDTH  lane i at bits [i*WIDTH +: WIDTH].
- busy  out  1  any lane not IDLE.
- err_count  out  ERR_W  saturating mismatch count.
- err_lane  out  LANES  sticky per-lane mismatch flag.

Behaviour:
- Reset (async, active-high): all outputs 0, divider 0, all lane FSMs in IDLE, config registers 0.
- Divider:
  - 2-bit counter, free-running out of reset regardless of enable.
  - tick_2f=1 in the cycle where the counter equals 3, so the first tick is the 4th clk_8f edge after reset release.
  - All lane state, valid and data changes occur only on edges where tick_2f=1, except enable deassertion.
- Config capture: burst_len, gap_len, lane_skew, mode and pattern are latched on the first tick with enable=1 while all lanes are IDLE. They are ignored until the next return to IDLE.
- Per-lane FSM, states IDLE, WAIT, BURST, GAP:
  - IDLE -> WAIT on capture tick; delay counter loaded with i*lane_skew, truncated to CFG_W+clog2(LANES) bits. Lane 0 with delay 0 goes directly to BURST.
  - WAIT: decrement each tick; at 0 -> BURST.
  - BURST: validout[i]=1 and data updates each tick; after max(burst_len,1) ticks -> GAP, or stay in BURST if gap_len=0.
  - GAP: validout[i]=0, data held; after gap_len ticks -> BURST.
- Data patterns:
  - First valid word per lane: increment 1; constant pattern; walking-one 1; alternate pattern.
  - Next word each subsequent BURST tick: increment +1 mod 2^WIDTH; constant unchanged; walking-one rotate left by 1; alternate toggles between pattern and ~pattern.
  - Sequence continues across gaps and does not restart.
- enable deassert: on the next clk_8f edge (not tick-gated) all validout=0 and all FSMs go to IDLE; data_out holds its last value. Re-enable restarts skew and patterns from their first words.
- Comparator: on every clk_8f edge with cmp_en=1 and enable=1:
  - m = popcount(ser_a ^ ser_b).
  - err_count += m, saturating at all-ones.
  - err_lane |= ser_a ^ ser_b.
  - Cleared only by reset.
  - Simultaneous mismatches on several lanes add all of them in the same cycle.
- busy = OR of (lane state != IDLE).
- Reset asserted mid-burst: immediate return to reset values with no further tick.

Test Plan:
- Reset then enable=1, LANES=2, burst_len=4, gap_len=2, lane_skew=1, mode=00 -> lane0 valid on ticks 1-4 with data 1,2,3,4, invalid on ticks 5-6, then data 5; lane1 starts one tick later with 1,2,3,4.
- gap_len=0, mode=10, WIDTH=8 -> continuous valid; data 01,02,04,...,80,01 (wraps after 8 ticks).
- mode=11, pattern=A5 -> data A5,5A,A5,...; mode=01 -> A5 constant; config changed mid-run is ignored until IDLE.
- enable dropped during BURST -> validout=0 on the next clk_8f edge, busy=0, data held; re-enable -> lane0 restarts at 1.
- cmp_en=1 with ser_a=2'b11, ser_b=2'b01 for 3 cycles -> err_count=3, err_lane=2'b10; both lanes differing for 1 cycle -> +2; forced near max -> saturates at FFFF.
- Reset asserted mid-run -> all outputs 0 immediately; first tick_2f arrives 4 edges after release.
